// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access, with req/ack sequencing and stalls.
// Optional ARB_ROUND_ROBIN_EN: alternate priority on simultaneous requests (default: DATA over FETCH).
module mem_port_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                i_req_i,
    input  logic [ADDR_W-1:0]   i_addr_i,
    output logic [DATA_W-1:0]   i_rdata_o,
    output logic                i_ready_o,
    output logic                i_stall_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [DATA_W/8-1:0] d_be_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                d_ready_o,
    output logic                d_stall_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_ack_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                err_o
);
    localparam int BE_W    = DATA_W / 8;
    localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DATA} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                i_ready_q, i_ready_d;
    logic                d_ready_q, d_ready_d;
    logic                err_q, err_d;
    logic                i_elig, d_elig;
    logic                grant_i, grant_d;
    logic                timeout_hit;

    // A requester completing this cycle still holds req; masking stops a duplicate grant.
    assign i_elig = i_req_i & ~i_ready_q;
    assign d_elig = d_req_i & ~d_ready_q;

`ifdef ARB_ROUND_ROBIN_EN
    logic prio_data_q;

    assign grant_d = (state_q == S_IDLE) & d_elig & (~i_elig | prio_data_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_data_q <= 1'b1;
        end else if (grant_d) begin
            prio_data_q <= 1'b0;
        end else if (grant_i) begin
            prio_data_q <= 1'b1;
        end
    end
`else
    assign grant_d = (state_q == S_IDLE) & d_elig;
`endif

    assign grant_i = (state_q == S_IDLE) & i_elig & ~grant_d;

    // Abort on the last allowed wait cycle, so mem_req_o is held for exactly TIMEOUT unacked cycles.
    assign timeout_hit = (TIMEOUT > 0) && !mem_ack_i && (cnt_q == CNT_W'(TO_LAST));

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (grant_d) begin
                    state_d = S_DATA;
                    addr_d  = d_addr_i;
                    we_d    = d_we_i;
                    be_d    = d_we_i ? d_be_i : '1;
                    wdata_d = d_wdata_i;
                end else if (grant_i) begin
                    state_d = S_FETCH;
                    addr_d  = i_addr_i;
                    we_d    = 1'b0;
                    be_d    = '1;
                    wdata_d = '0;
                end
            end
            S_FETCH, S_DATA: begin
                if (mem_ack_i) begin
                    state_d = S_IDLE;
                    if (state_q == S_FETCH) begin
                        i_rdata_d = mem_rdata_i;
                        i_ready_d = 1'b1;
                    end else begin
                        d_rdata_d = we_q ? '0 : mem_rdata_i;
                        d_ready_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    if (state_q == S_FETCH) begin
                        i_rdata_d = '0;
                        i_ready_d = 1'b1;
                    end else begin
                        d_rdata_d = '0;
                        d_ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
        if (rst_i) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
            err_q     <= err_d;
        end
    end

    assign mem_req_o   = (state_q != S_IDLE);
    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign i_rdata_o   = i_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign i_ready_o   = i_ready_q;
    assign d_ready_o   = d_ready_q;
    assign err_o       = err_q;
    assign i_stall_o   = i_req_i & ~i_ready_q;
    assign d_stall_o   = d_req_i & ~d_ready_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch stage and the memory-access stage of the 5-stage RISC-V pipeline.
- Arbitrates between the two requesters, sequences each memory transaction with a req/ack handshake, and returns data and a one-cycle ready pulse.
- Drives the per-stage stall signals that the pipeline control consumes.
- Sits between the fetch and memory stages and the memory model.

Parameters:
- ADDR_W, 64, address width; matches the 64-bit PC.
- DATA_W, 64, memory data width.
- TIMEOUT, 255, maximum cycles to wait for mem_ack_i. 0 disables the timeout.

Ports:
- clk_i, in, 1, clock; all logic is on the rising edge.
- rst_i, in, 1, reset; synchronous, active-high.
- i_req_i, in, 1, fetch request; level-held until i_ready_o.
- i_addr_i, in, ADDR_W, fetch address; stable while i_req_i=1.
- i_rdata_o, out, DATA_W, fetched data; valid with i_ready_o.
- i_ready_o, out, 1, one-cycle fetch completion pulse.
- i_stall_o, out, 1, i_req_i & ~i_ready_o.
- d_req_i, in, 1, data request; level-held until d_ready_o.
- d_we_i, in, 1, 1 = store, 0 = load.
- d_be_i, in, DATA_W/8, store byte enables.
- d_addr_i, in, ADDR_W, data address.
- d_wdata_i, in, DATA_W, store data.
- d_rdata_o, out, DATA_W, load data; valid with d_ready_o.
- d_ready_o, out, 1, one-cycle data completion pulse.
- d_stall_o, out, 1, d_req_i & ~d_ready_o.
- mem_req_o, out, 1, memory request; held until mem_ack_i.
- mem_we_o, out, 1, memory write enable.
- mem_be_o, out, DATA_W/8, byte enables; all ones for fetch and load.
- mem_addr_o, out, ADDR_W, memory address.
- mem_wdata_o, out, DATA_W, memory write data.
- mem_ack_i, in, 1, memory completion; read data valid this cycle.
- mem_rdata_i, in, DATA_W, memory read data.
- err_o, out, 1, one-cycle pulse coinciding with the ready pulse of a timed-out transaction.

Behaviour:
- Reset: all outputs 0. State IDLE, wait counter 0, priority pointer to DATA.
- States: IDLE, FETCH, DATA.
- IDLE, grant decision: d_req_i wins over i_req_i (fixed priority).
  - On a grant, register address, we, be and wdata, then move to FETCH or DATA.
  - A fetch grant forces mem_we_o=0 and mem_be_o all ones.
- Masking: a requester whose ready_o is high in the current cycle is ignored for granting in that cycle, so a still-held req is not re-served.
- FETCH/DATA:
  - mem_req_o=1 with the registered fields stable.
  - The wait counter increments every cycle mem_ack_i=0.
- On mem_ack_i=1:
  - Register mem_rdata_i into the granted requester's rdata_o. A store returns 0.
  - Pulse that requester's ready_o in the next cycle.
  - Return to IDLE. mem_req_o drops the cycle after ack.
- Latency: request sampled in IDLE at cycle N; mem_req_o at N+1; ack at N+1+W; ready at N+2+W.
- Back-to-back: arbitration in the ready cycle serves only the other requester (see Masking). A pending other request is granted in that cycle.
- Timeout (TIMEOUT>0): when the counter reaches TIMEOUT with no ack:
  - Abort the transaction and drop mem_req_o.
  - Pulse ready_o and err_o together; rdata_o=0.
  - Return to IDLE.
- mem_ack_i in IDLE, or in the cycle after a timeout abort: ignored.
- rdata_o holds its value between transactions.
- Reset mid-transaction:
  - Next cycle the state is IDLE and mem_req_o=0.
  - No ready or err pulse.
  - A stale ack is ignored.
- Requester drops req before ready (protocol violation): the transaction completes to memory; the ready pulse is still emitted.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: when both requests arrive in IDLE, the requester not served last wins. The priority pointer updates on every grant; the reset pointer favours DATA.
- Undefined: fixed DATA-over-FETCH priority; the pointer logic is absent.

Test Plan:
1. Reset, then i_req_i=1, i_addr_i=0x40, mem_ack_i after 2 wait cycles with mem_rdata_i=0x00000013 -> mem_req_o high cycles 1-3, i_ready_o pulse at cycle 4, i_rdata_o=0x13, i_stall_o high cycles 0-3.
2. i_req_i and d_req_i (load 0x1000) both asserted at cycle 0, zero-wait memory -> data served first, d_ready_o at cycle 2, fetch granted at cycle 2, i_ready_o at cycle 4. With ARB_ROUND_ROBIN_EN, a second simultaneous pair serves fetch first.
3. Store d_addr_i=0x2000, d_wdata_i=0xDEADBEEF, d_be_i=0x0F -> mem_we_o=1, mem_be_o=0x0F, mem_wdata_o=0xDEADBEEF, d_rdata_o=0.
4. TIMEOUT=4, mem_ack_i never asserted -> mem_req_o drops after 4 wait cycles, d_ready_o and err_o pulse together; a late ack is ignored.
5. rst_i asserted while in FETCH -> next cycle mem_req_o=0 and state IDLE, no i_ready_o; a stale ack the following cycle produces no pulse.
6. Fetch held high continuously with a 1-wait memory -> one ready pulse per transaction, never two consecutive ready cycles, no duplicate grant during the ready cycle.
